digit_serial_subtractor: RTL

- Multi-cycle subtractor for the polynomial-arithmetic datapath. It computes out = in1 - in2 - bin (mod 2^NUM_WIDTH_LENGTH) with a borrow-out.
- Processes one 4-bit digit per clock and ripples a registered borrow, trading latency for area.
- It is the subtraction counterpart of the carry-select adder and is used for coefficient differences and reductions.
- Valid/ready handshakes on both input and output; one operation in flight at a time.

---
 rtl/digit_serial_subtractor_pkg.sv | 12 +
 rtl/digit_serial_subtractor_sub4bit.sv | 19 +
 rtl/digit_serial_subtractor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/digit_serial_subtractor_pkg.sv
// Shared constants and FSM state type for the digit-serial arithmetic blocks.
package digit_serial_subtractor_pkg;

  localparam int DIGIT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_serial_subtractor_sub4bit.sv
// Combinational one-digit subtractor with borrow-in/borrow-out; mirror of adder4bit.
module sub4bit
  import digit_serial_subtractor_pkg::*;
(
  input  logic [DIGIT_WIDTH-1:0] in1,
  input  logic [DIGIT_WIDTH-1:0] in2,
  input  logic                   bin,
  output logic [DIGIT_WIDTH-1:0] out,
  output logic                   bout
);

  logic [DIGIT_WIDTH:0] diff;

  // The extra top bit of the widened difference goes high exactly when the digit underflows.
  assign diff = {1'b0, in1} - {1'b0, in2} - {{DIGIT_WIDTH{1'b0}}, bin};
  assign out  = diff[DIGIT_WIDTH-1:0];
  assign bout = diff[DIGIT_WIDTH];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle subtractor: out = in1 - in2 - bin, one 4-bit digit per clock with a
// registered borrow, valid/ready on both sides and one operation in flight.
module digit_serial_subtractor
  import digit_serial_subtractor_pkg::*;
#(
  parameter int NUM_WIDTH_LENGTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_WIDTH_LENGTH-1:0] in1,
  input  logic [NUM_WIDTH_LENGTH-1:0] in2,
  input  logic                        bin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WIDTH_LENGTH-1:0] out,
  output logic                        bout
);

  localparam int NDIG  = NUM_WIDTH_LENGTH / DIGIT_WIDTH;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if ((NUM_WIDTH_LENGTH % DIGIT_WIDTH) != 0 || NUM_WIDTH_LENGTH < 8) begin : g_bad_width
    $error("digit_serial_subtractor: NUM_WIDTH_LENGTH must be a multiple of 4 and at least 8");
  end

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        borrow_q, borrow_d;
  logic [NUM_WIDTH_LENGTH-1:0] in1_q, in1_d;
  logic [NUM_WIDTH_LENGTH-1:0] in2_q, in2_d;
  logic [NUM_WIDTH_LENGTH-1:0] out_q, out_d;
  logic                        bout_q, bout_d;
  logic                        in_ready_q, in_ready_d;
  logic                        out_valid_q, out_valid_d;

  logic [DIGIT_WIDTH-1:0] dig_a, dig_b, dig_r;
  logic                   dig_bout;

  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (cnt_q == CNT_W'(d)) begin
        dig_a = in1_q[d*DIGIT_WIDTH +: DIGIT_WIDTH];
        dig_b = in2_q[d*DIGIT_WIDTH +: DIGIT_WIDTH];
      end
    end
  end

  sub4bit u_sub4bit (
    .in1  (dig_a),
    .in2  (dig_b),
    .bin  (borrow_q),
    .out  (dig_r),
    .bout (dig_bout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    out_d    = out_q;
    bout_d   = bout_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          in1_d    = in1;
          in2_d    = in2;
          borrow_d = bin;
          cnt_d    = '0;
          out_d    = '0;
          bout_d   = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int d = 0; d < NDIG; d++) begin
          if (cnt_q == CNT_W'(d)) begin
            out_d[d*DIGIT_WIDTH +: DIGIT_WIDTH] = dig_r;
          end
        end
        borrow_d = dig_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_DIG) begin
          bout_d  = dig_bout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are decoded from the next state so they stay purely registered outputs.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      out_q       <= '0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      out_q       <= out_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign bout      = bout_q;

endmodule
